// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Bus-mapped, multiplexed 7-segment driver. GROUPS displays of DIGITS digits
// each are scanned in lock-step from one hex DATA register. A CTRL register
// holds per-digit decimal points, per-digit blanking and the scan enable.
//
// Register map (Addr):
//   0  DATA  [4*GROUPS*DIGITS-1:0] hex nibbles; group g owns [4*DIGITS*g +: 4*DIGITS]
//   1  CTRL  [7:0] dp mask, [15:8] blank mask, [16] scan_en
//
// Optional build macro:
//   SEVSEG_LZB_EN  leading-zero blanking per group (least significant digit
//                  is never auto-blanked, dp still follows the dp mask).
//
// Outputs are fully registered: sel and seg always change on the same edge,
// so a digit select never meets a segment pattern meant for another digit.

module seven_seg_scan_ctrl #(
    parameter int          GROUPS      = 2,
    parameter int          DIGITS      = 4,
    parameter int          REFRESH_DIV = 1250000,
    parameter logic [31:0] RESET_VAL   = 32'h23333333
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       We,
    input  logic                       Addr,
    input  logic [31:0]                Din,
    output logic [31:0]                Dout,
    output logic [8*GROUPS-1:0]        seg,
    output logic [DIGITS*GROUPS-1:0]   sel
);

    localparam int N    = 4 * GROUPS * DIGITS;
    localparam int SELW = DIGITS * GROUPS;
    localparam int GW   = 4 * DIGITS;
    localparam int CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW   = $clog2(DIGITS);

    localparam logic [CW-1:0] CNT_RELOAD = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [N-1:0]  DATA_RST   = RESET_VAL[N-1:0];

    // One select bit per group at position idx inside that group's field.
    function automatic logic [SELW-1:0] selOneHot(input int idx);
        logic [SELW-1:0] r;
        r = '0;
        for (int g = 0; g < GROUPS; g++) begin
            r = r | (SELW'(1) << (g * DIGITS + idx));
        end
        return r;
    endfunction

    localparam logic [SELW-1:0] SEL_RST = selOneHot(DIGITS - 1);

    // Active-low {a,b,c,d,e,f,g} patterns for hex digits.
    function automatic logic [6:0] hexToSeg(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0:    p = 7'b0000001;
            4'h1:    p = 7'b1001111;
            4'h2:    p = 7'b0010010;
            4'h3:    p = 7'b0000110;
            4'h4:    p = 7'b1001100;
            4'h5:    p = 7'b0100100;
            4'h6:    p = 7'b0100000;
            4'h7:    p = 7'b0001111;
            4'h8:    p = 7'b0000000;
            4'h9:    p = 7'b0000100;
            4'hA:    p = 7'b0001000;
            4'hB:    p = 7'b1100000;
            4'hC:    p = 7'b0110001;
            4'hD:    p = 7'b1000010;
            4'hE:    p = 7'b0110000;
            default: p = 7'b0111000;
        endcase
        return p;
    endfunction

    logic [N-1:0]      data_q,      data_d;
    logic [7:0]        dpMask_q,    dpMask_d;
    logic [7:0]        blankMask_q, blankMask_d;
    logic              scanEn_q,    scanEn_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic [IW-1:0]     idx_q,       idx_d;
    logic [SELW-1:0]   sel_q,       sel_d;
    logic [8*GROUPS-1:0] seg_q,     seg_d;

    logic [IW-1:0]       idxAdv;
    logic [SELW-1:0]     selAdv;
    logic [8*GROUPS-1:0] segAdv;
    logic [GW-1:0]       grpWord;
    logic [3:0]          nib;
    logic [2:0]          gIdx;
    logic                lzb;
    int                  nibPos;

    // Display contents for the digit the scan moves to next, built from the
    // register values currently held (a write in the same cycle is not seen).
    always_comb begin
        idxAdv  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        selAdv  = selOneHot(int'(idxAdv));
        segAdv  = '1;
        grpWord = '0;
        nib     = '0;
        gIdx    = '0;
        lzb     = 1'b0;
        nibPos  = DIGITS - 1 - int'(idxAdv);
        for (int g = 0; g < GROUPS; g++) begin
            grpWord = GW'(data_q >> (GW * g));
            nib     = 4'(grpWord >> (4 * nibPos));
            gIdx    = 3'(g * DIGITS + int'(idxAdv));
`ifdef SEVSEG_LZB_EN
            lzb = (nibPos != 0);
            for (int m = 0; m < DIGITS; m++) begin
                if ((m >= nibPos) && (4'(grpWord >> (4 * m)) != 4'h0)) begin
                    lzb = 1'b0;
                end
            end
`else
            lzb = 1'b0;
`endif
            if (blankMask_q[gIdx]) begin
                segAdv[8*g +: 8] = 8'hFF;
            end else if (lzb) begin
                segAdv[8*g +: 8] = {7'h7F, ~dpMask_q[gIdx]};
            end else begin
                segAdv[8*g +: 8] = {hexToSeg(nib), ~dpMask_q[gIdx]};
            end
        end
    end

    // Next-state: bus writes, refresh counter, digit index and display outputs.
    always_comb begin
        data_d      = data_q;
        dpMask_d    = dpMask_q;
        blankMask_d = blankMask_q;
        scanEn_d    = scanEn_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sel_d       = sel_q;
        seg_d       = seg_q;

        if (We) begin
            if (Addr) begin
                dpMask_d    = Din[7:0];
                blankMask_d = Din[15:8];
                scanEn_d    = Din[16];
            end else begin
                data_d = Din[N-1:0];
            end
        end

        // While disabled the counter is parked at its reload value so that
        // re-enabling always gives a full step before the next digit.
        if (!scanEn_q) begin
            cnt_d = CNT_RELOAD;
            sel_d = '0;
            seg_d = '1;
        end else if (cnt_q == '0) begin
            cnt_d = CNT_RELOAD;
            idx_d = idxAdv;
            sel_d = selAdv;
            seg_d = segAdv;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State registers with asynchronous reset to the power-up display state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= DATA_RST;
            dpMask_q    <= '0;
            blankMask_q <= '0;
            scanEn_q    <= 1'b1;
            cnt_q       <= CNT_RELOAD;
            idx_q       <= IDX_LAST;
            sel_q       <= SEL_RST;
            seg_q       <= '1;
        end else begin
            data_q      <= data_d;
            dpMask_q    <= dpMask_d;
            blankMask_q <= blankMask_d;
            scanEn_q    <= scanEn_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    // Read mux; unused register bits read as zero.
    always_comb begin
        Dout = '0;
        if (Addr) begin
            Dout[7:0]  = dpMask_q;
            Dout[15:8] = blankMask_q;
            Dout[16]   = scanEn_q;
        end else begin
            Dout[N-1:0] = data_q;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl
// Directed bench for seven_seg_scan_ctrl (GROUPS=2, DIGITS=4, REFRESH_DIV=4).
// A cycle model pushes each expected display change into a queue; a monitor
// pops and compares whenever the DUT's {sel,seg} changes, including the cycle.
// Honours SEVSEG_LZB_EN the same way the design build does.

module tb_seven_seg_scan_ctrl;

    localparam logic [23:0] RST_DISP = {8'b1000_1000, 16'hFFFF};

    logic        clk = 1'b0;
    logic        rst;
    logic        We;
    logic        Addr;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [15:0] seg;
    logic [7:0]  sel;

    typedef struct {
        logic [23:0] disp;
        int          cycle;
    } expEntry_t;

    expEntry_t   expQ[$];
    int          checks   = 0;
    int          failures = 0;
    int          cycleCount = 0;
    logic        monOn = 1'b0;
    logic [23:0] lastDisp;
    logic [23:0] monCur;
    expEntry_t   monEntry;

    logic [31:0] mData;
    logic [7:0]  mDp;
    logic [7:0]  mBlank;
    logic        mEn;
    int          mCnt;
    int          mIdx;
    logic [23:0] mDisp;

    seven_seg_scan_ctrl #(
        .GROUPS      (2),
        .DIGITS      (4),
        .REFRESH_DIV (4),
        .RESET_VAL   (32'h23333333)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .We   (We),
        .Addr (Addr),
        .Din  (Din),
        .Dout (Dout),
        .seg  (seg),
        .sel  (sel)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Cycle index used to time-stamp expected display changes.
    always @(posedge clk) cycleCount++;

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Expected {sel,seg} while digit idx (sel bit idx) is lit in both groups.
    function automatic logic [23:0] expDisp(input int idx, input logic [31:0] d,
                                            input logic [7:0] dp, input logic [7:0] bl);
        logic [7:0]  s;
        logic [15:0] sg;
        logic [15:0] word;
        logic [3:0]  n;
        logic        lz;
        int          gi;
        int          pos;
        s  = '0;
        sg = '1;
        for (int g = 0; g < 2; g++) begin
            gi   = g * 4 + idx;
            pos  = 3 - idx;
            word = d[16*g +: 16];
            n    = 4'(word >> (4 * pos));
`ifdef SEVSEG_LZB_EN
            lz = (pos != 0) && ((word >> (4 * pos)) == 16'h0);
`else
            lz = 1'b0;
`endif
            s[gi] = 1'b1;
            if (bl[gi])      sg[8*g +: 8] = 8'hFF;
            else if (lz)     sg[8*g +: 8] = {7'h7F, ~dp[gi]};
            else             sg[8*g +: 8] = {hexSeg(n), ~dp[gi]};
        end
        return {s, sg};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pushIfChanged(input logic [23:0] nd);
        expEntry_t e;
        if (nd != mDisp) begin
            e.disp  = nd;
            e.cycle = cycleCount;
            expQ.push_back(e);
            mDisp = nd;
        end
    endtask

    task automatic resetModel();
        mData  = 32'h23333333;
        mDp    = 8'h00;
        mBlank = 8'h00;
        mEn    = 1'b1;
        mCnt   = 3;
        mIdx   = 3;
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled.
    task automatic stepClock();
        logic [23:0] nd;
        @(posedge clk);
        #1;
        nd = mDisp;
        if (!mEn) begin
            mCnt = 3;
            nd   = 24'h00FFFF;
        end else if (mCnt == 0) begin
            mCnt = 3;
            mIdx = (mIdx + 1) % 4;
            nd   = expDisp(mIdx, mData, mDp, mBlank);
        end else begin
            mCnt--;
        end
        if (We) begin
            if (Addr) begin
                mDp    = Din[7:0];
                mBlank = Din[15:8];
                mEn    = Din[16];
            end else begin
                mData = Din;
            end
        end
        pushIfChanged(nd);
    endtask

    task automatic applyStimulus(input logic addr, input logic [31:0] din);
        We   = 1'b1;
        Addr = addr;
        Din  = din;
        stepClock();
        We   = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic addr, input logic [31:0] exp);
        Addr = addr;
        #1;
        checkOutput(tag, Dout, exp);
    endtask

    // Scoreboard side: every DUT display change must match the next queued entry.
    always @(negedge clk) begin
        if (monOn) begin
            monCur = {sel, seg};
            if (monCur !== lastDisp) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_change", {8'h0, monCur}, {8'h0, lastDisp});
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("disp", {8'h0, monCur}, {8'h0, monEntry.disp});
                    checkOutput("disp_cycle", cycleCount, monEntry.cycle);
                end
                lastDisp = monCur;
            end
        end
    end

    initial begin
        rst  = 1'b1;
        We   = 1'b0;
        Addr = 1'b0;
        Din  = '0;
        resetModel();
        mDisp    = RST_DISP;
        lastDisp = RST_DISP;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_sel", {24'h0, sel}, 32'h88);
        checkOutput("rst_seg", {16'h0, seg}, 32'hFFFF);
        readCheck("rst_dout_data", 1'b0, 32'h23333333);
        readCheck("rst_dout_ctrl", 1'b1, 32'h00010000);
        rst   = 1'b0;
        monOn = 1'b1;

        // Scan reset data for two full rotations
        repeat (32) stepClock();
        readCheck("dout_data_reset", 1'b0, 32'h23333333);

        // DATA write mid-step
        for (int i = 0; i < 8 && mCnt != 2; i++) stepClock();
        applyStimulus(1'b0, 32'h0000ABCD);
        readCheck("dout_data_abcd", 1'b0, 32'h0000ABCD);
        repeat (16) stepClock();

        // DATA write on exactly the advance edge
        for (int i = 0; i < 8 && mCnt != 0; i++) stepClock();
        applyStimulus(1'b0, 32'h12345678);
        repeat (16) stepClock();

        // CTRL: dp on global digits 0 and 7, blank global digit 1; junk upper bits
        applyStimulus(1'b1, 32'hFFFF0281);
        readCheck("dout_ctrl", 1'b1, 32'h00010281);
        repeat (16) stepClock();

        // Scan disable, hold, re-enable
        applyStimulus(1'b1, 32'h00000281);
        stepClock();
        checkOutput("dis_sel", {24'h0, sel}, 32'h0);
        checkOutput("dis_seg", {16'h0, seg}, 32'hFFFF);
        repeat (20) stepClock();
        checkOutput("hold_sel", {24'h0, sel}, 32'h0);
        readCheck("dout_ctrl_dis", 1'b1, 32'h00000281);
        applyStimulus(1'b1, 32'h00010281);
        repeat (3) stepClock();
        checkOutput("reen_wait_sel", {24'h0, sel}, 32'h0);
        stepClock();
        checkOutput("reen_adv_sel", {24'h0, sel}, {24'h0, mDisp[23:16]});
        repeat (12) stepClock();

        // Asynchronous reset pulse between edges, mid-scan
        for (int i = 0; i < 16 && !(mCnt == 2 && mIdx != 3); i++) stepClock();
        #1;
        rst = 1'b1;
        resetModel();
        pushIfChanged(RST_DISP);
        #1;
        rst = 1'b0;
        checkOutput("arst_sel", {24'h0, sel}, 32'h88);
        checkOutput("arst_seg", {16'h0, seg}, 32'hFFFF);
        readCheck("arst_dout_data", 1'b0, 32'h23333333);
        readCheck("arst_dout_ctrl", 1'b1, 32'h00010000);
        repeat (16) stepClock();

        @(negedge clk);
        #1;
        checkOutput("queue_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
